// File: rtl/banked_mem_arbiter.sv
// banked_mem_arbiter
//   Shares a two-bank memory (bank picked by address MSB) between two
//   requesters. Each access runs IDLE -> SETUP -> ACCESS (ACC_CYCLES) -> DONE.
//   All outputs are registered.
//
//   Optional build macro: ARB_ROUND_ROBIN_EN
//     defined   : on contention the requester not granted last wins
//     undefined : fixed priority, requester 0 wins on contention
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rN_req/rw/addr/wdata     requester N access (rw: 1 = read, 0 = write)
//   rN_gnt, rN_done          ownership and one-cycle completion pulse
//   rdata                    registered read data, held until the next read completes
//   mem_addr/cs/rw/wdata     shared bank bus; cs is one-hot or zero
//   mem_rdata                OR of both bank outputs
module banked_mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int ACC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [1:0]        mem_cs,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              own;       // current owner: 0 = r0, 1 = r1
  logic              bank;      // latched address MSB
  logic              any_req;
  logic              win;
  logic              acc_last;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_rw;

`ifdef ARB_ROUND_ROBIN_EN
  logic last;                   // requester granted most recently
`endif

  assign any_req   = r0_req | r1_req;
  assign acc_last  = (cnt == 4'(ACC_CYCLES - 1));
  assign sel_addr  = win ? r1_addr  : r0_addr;
  assign sel_wdata = win ? r1_wdata : r0_wdata;
  assign sel_rw    = win ? r1_rw    : r0_rw;

  // Winner select; only meaningful while in IDLE with a request pending.
  always_comb begin
    win = r1_req;               // lone requester (or none) picks itself
    if (r0_req && r1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~last;
`else
      win = 1'b0;
`endif
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (acc_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and datapath. mem_addr/mem_rw/mem_wdata double as the
  // latched request, so they are loaded at the IDLE edge and are already
  // stable for a full SETUP cycle before chip select rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cs    <= '0;
      mem_rw    <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      rdata     <= '0;
      cnt       <= '0;
      own       <= 1'b0;
      bank      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last      <= 1'b1;        // r0 wins the first contention
`endif
    end else begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          own       <= win;
          r0_gnt    <= ~win;
          r1_gnt    <= win;
          bank      <= sel_addr[ADDR_W-1];
          mem_addr  <= sel_addr[ADDR_W-2:0];
          mem_rw    <= sel_rw;
          mem_wdata <= sel_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last      <= win;
`endif
        end
        SETUP: begin
          cnt    <= '0;
          mem_cs <= bank ? 2'b10 : 2'b01;
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (acc_last) begin
            // mem_rw still holds the request direction here
            if (mem_rw) rdata <= mem_rdata;
            mem_cs  <= '0;
            mem_rw  <= 1'b1;
            r0_done <= ~own;
            r1_done <= own;
          end
        end
        DONE: begin
          r0_gnt <= 1'b0;
          r1_gnt <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Randomized bench for banked_mem_arbiter: transaction-level reference
// (flat 2 KB shadow memory plus expected phase timing) against a two-bank
// RAM model hooked to the DUT bus.
module tb_banked_mem_arbiter;
  localparam int ACC = 3;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, rw;
  logic [10:0] addr [2];
  logic [7:0]  wdata [2];
  logic        r0_gnt, r1_gnt, r0_done, r1_done;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [1:0]  mem_cs, gnt, done;
  logic        mem_rw;

  logic [7:0]  bank0 [1024];
  logic [7:0]  bank1 [1024];
  logic [7:0]  ref_mem [2048];
  logic [7:0]  rdata_exp;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  banked_mem_arbiter #(.ADDR_W(11), .DATA_W(8), .ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r0_rw(rw[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r1_req(req[1]), .r1_rw(rw[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_gnt(r1_gnt), .r1_done(r1_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_rw(mem_rw),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign gnt  = {r1_gnt, r0_gnt};
  assign done = {r1_done, r0_done};

  // Two level-sensitive banks; an unselected bank drives 0.
  assign mem_rdata = (mem_cs[0] ? bank0[mem_addr] : 8'h00) |
                     (mem_cs[1] ? bank1[mem_addr] : 8'h00);

  always @(posedge clk) begin
    if (mem_cs[0] && !mem_rw) bank0[mem_addr] <= mem_wdata;
    if (mem_cs[1] && !mem_rw) bank1[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Safety properties checked every cycle.
  always @(negedge clk) begin
    chk("cs_not_both", {31'd0, mem_cs == 2'b11}, 32'd0);
    chk("gnt_not_both", {31'd0, r0_gnt & r1_gnt}, 32'd0);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    rdata_exp = 8'h00;
  endtask

  // One access from a lone requester, checked phase by phase.
  task automatic single(input int who, input bit rd, input logic [10:0] a,
                        input logic [7:0] d, input bit drop);
    logic [1:0] cs_exp, g_exp;
    cs_exp = a[10] ? 2'b10 : 2'b01;
    g_exp  = (who == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    req[who] = 1'b1; rw[who] = rd; addr[who] = a; wdata[who] = d;
    @(negedge clk);                       // SETUP
    chk("setup_gnt", gnt, g_exp);
    chk("setup_cs", mem_cs, 2'b00);
    chk("setup_addr", mem_addr, a[9:0]);
    chk("setup_rw", mem_rw, rd);
    // late input changes must not disturb the latched access
    addr[who] = 11'($urandom); wdata[who] = 8'($urandom); rw[who] = 1'($urandom);
    if (drop) req[who] = 1'b0;
    for (int i = 0; i < ACC; i++) begin
      @(negedge clk);                     // ACCESS
      chk("acc_cs", mem_cs, cs_exp);
      chk("acc_addr", mem_addr, a[9:0]);
      chk("acc_rw", mem_rw, rd);
      if (!rd) chk("acc_wdata", mem_wdata, d);
      chk("acc_no_done", done, 2'b00);
    end
    if (rd) rdata_exp = ref_mem[a];
    else    ref_mem[a] = d;
    @(negedge clk);                       // DONE: cycle ACC+2
    chk("done_pulse", done, g_exp);
    chk("done_gnt", gnt, g_exp);
    chk("done_cs", mem_cs, 2'b00);
    chk("done_rw", mem_rw, 1'b1);
    chk("done_rdata", rdata, rdata_exp);
    req[who] = 1'b0;
    @(negedge clk);                       // back in IDLE
    chk("idle_gnt", gnt, 2'b00);
    chk("idle_done", done, 2'b00);
    chk("idle_cs", mem_cs, 2'b00);
  endtask

  initial begin
    logic [7:0]  v;
    logic [10:0] a;
    int          waitc, nbad, exp_who;
    bit          seen;

    rst = 1'b1;
    req = 2'b00; rw = 2'b11;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    rdata_exp = 8'h00;
    for (int i = 0; i < 2048; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      if (i < 1024) bank0[i] <= v;
      else          bank1[i-1024] <= v;
    end
    ref_mem[25] = 8'h5A;
    bank0[25]  <= 8'h5A;

    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_cs", mem_cs, 2'b00);
    chk("rst_rw", mem_rw, 1'b1);
    chk("rst_addr", mem_addr, 10'd0);
    chk("rst_wdata", mem_wdata, 8'd0);
    chk("rst_rdata", rdata, 8'd0);
    rst = 1'b0;

    // directed cases
    single(0, 1'b1, 11'd25, 8'h00, 1'b0);
    chk("read25", rdata, 8'h5A);
    single(1, 1'b0, 11'd1030, 8'hC3, 1'b0);
    single(1, 1'b1, 11'd1030, 8'h00, 1'b0);
    chk("read1030", rdata, 8'hC3);
    chk("bank0_6_kept", bank0[6], ref_mem[6]);
    single(0, 1'b1, 11'd1023, 8'h00, 1'b0);
    single(1, 1'b1, 11'd1024, 8'h00, 1'b0);

    // random single-requester traffic
    for (int n = 0; n < 40; n++)
      single($urandom_range(0, 1), 1'($urandom), 11'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0);

    // reset during ACCESS; write data equals current contents so a partial
    // write leaves the reference image valid either way
    a = 11'($urandom);
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b0; addr[0] = a; wdata[0] = ref_mem[a];
    @(negedge clk);                       // SETUP
    req[0] = 1'b0;
    @(negedge clk);                       // ACCESS
    chk("pre_rst_cs", mem_cs, a[10] ? 2'b10 : 2'b01);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs", mem_cs, 2'b00);
    chk("midrst_rw", mem_rw, 1'b1);
    chk("midrst_gnt", gnt, 2'b00);
    chk("midrst_done", done, 2'b00);
    rst = 1'b0;
    rdata_exp = 8'h00;
    seen = 1'b0;
    repeat (ACC + 4) begin
      @(negedge clk);
      if (done != 2'b00 || mem_cs != 2'b00) seen = 1'b1;
    end
    chk("midrst_quiet", seen, 1'b0);
    single(0, 1'b1, 11'($urandom), 8'h00, 1'b1);
    single(1, 1'b0, 11'($urandom), 8'($urandom), 1'b1);

    // contention: both hold read requests continuously
    do_reset();
    @(negedge clk);
    addr[0] = 11'($urandom); addr[1] = 11'($urandom);
    rw = 2'b11; req = 2'b11;
    for (int g = 0; g < 6; g++) begin
      waitc = 0;
      @(negedge clk); waitc++;
      while (done == 2'b00 && waitc < 40) begin
        @(negedge clk); waitc++;
      end
      if (done == 2'b00) begin
        chk("cont_timeout", 32'd1, 32'd0);
        break;
      end
      exp_who = RR ? (g % 2) : 0;
      chk("cont_who", r1_done, exp_who);
      chk("cont_gap", waitc, (g == 0) ? ACC + 2 : ACC + 3);
      chk("cont_rdata", rdata, ref_mem[addr[r1_done]]);
    end
    req = 2'b00;
    repeat (ACC + 4) @(negedge clk);

    // final memory image against the reference
    nbad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (bank0[i] !== ref_mem[i])      nbad++;
      if (bank1[i] !== ref_mem[i+1024]) nbad++;
    end
    chk("mem_image", nbad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit in case the main sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got stalled expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/banked_mem_arbiter.md
Name: banked_mem_arbiter

Overview:
- Clocked controller that shares the 2 KB banked memory (two 1Kx8 RAM banks, bank select on address MSB) between two requesters.
- Arbitrates between the requesters, sequences each access as SETUP, ACCESS and DONE phases, and drives the bank chip selects and the read/write line.
- Read data is registered, and completion is signalled with a one-cycle pulse.
- Sits between the requesters and the RAM banks, replacing direct decoder and chip-select driving.

Parameters:
ADDR_W, 11, full byte address width; the MSB selects the bank, the low ADDR_W-1 bits address within the bank
DATA_W, 8, data width
ACC_CYCLES, 1, number of cycles chip select is held asserted per access; legal range 1..15

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
r0_req  in  1  requester 0 access request; held until r0_done
r0_rw  in  1  requester 0 direction: 1 = read, 0 = write
r0_addr  in  ADDR_W  requester 0 byte address
r0_wdata  in  DATA_W  requester 0 write data
r0_gnt  out  1  requester 0 owns the memory
r0_done  out  1  one-cycle pulse: requester 0 access complete
r1_req, r1_rw, r1_addr, r1_wdata, r1_gnt, r1_done  same as above, for requester 1
rdata  out  DATA_W  registered read data; valid in the done cycle, held until the next read completes
mem_addr  out  ADDR_W-1  in-bank address to both banks
mem_cs  out  2  bank chip selects; bit0 = bank for MSB 0, bit1 = bank for MSB 1; one-hot or zero
mem_rw  out  1  to both banks; 1 = read, 0 = write
mem_wdata  out  DATA_W  write data to both banks
mem_rdata  in  DATA_W  OR of both bank outputs; an unselected bank outputs 0

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - state = IDLE, mem_cs = 0, mem_rw = 1, mem_addr = 0, mem_wdata = 0.
  - r0_gnt = r1_gnt = 0, r0_done = r1_done = 0, rdata = 0.
  - Last-grant pointer = 1, so requester 0 wins the first contention.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose a winner (see arbitration), latch its addr, rw and wdata, set its gnt, go to SETUP.
- SETUP (1 cycle):
  - mem_addr = latched addr[ADDR_W-2:0], mem_rw = latched rw, mem_wdata = latched wdata, mem_cs = 0.
  - Address and direction are stable before select, because the RAM is level-sensitive.
- ACCESS (ACC_CYCLES cycles):
  - mem_cs[latched addr MSB] = 1; the other select bit stays 0.
  - A 4-bit counter counts the cycles.
  - On the last ACCESS cycle of a read, rdata <= mem_rdata. Writes leave rdata unchanged.
  - Go to DONE.
- DONE (1 cycle):
  - mem_cs = 0, mem_rw = 1, winner's done = 1, winner's gnt = 1.
  - Next state is IDLE, which clears gnt.
- Latency: if req is sampled in IDLE at edge 0, done is high in cycle ACC_CYCLES+2. The next arbitration is no earlier than cycle ACC_CYCLES+3. There is one dead IDLE cycle between back-to-back accesses.
- Request rules:
  - Requests that arrive while a transaction is in flight wait.
  - If the winner drops req mid-transaction, it is ignored; the access completes and done still pulses.
  - If req is still high in the IDLE cycle after done, it is a new request.
- Address and data changes after latching have no effect on the current access.
- At most one gnt is high, and at most one mem_cs bit is high, at any time.
- Bank boundary: addresses 1023 and 1024 select different banks (mem_cs = 01 vs 10); mem_addr is 1023 and 0 respectively. There is no wrap across banks.
- Reset mid-operation: at the reset edge, cs drops and the FSM goes to IDLE. No done pulse is produced, and a partial write is not retried.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on contention in IDLE, the requester not granted last wins. The pointer updates on each grant.
- Undefined: fixed priority; requester 0 always wins on contention and the pointer logic is not built.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Read, single requester (ACC_CYCLES=1), bank0[25] preloaded to 0x5A:
  - Stimulus: r0 read addr 25.
  - Response: mem_cs=01 for 1 cycle with mem_addr=25; r0_done in cycle 3; rdata=0x5A.
- Write then read in the upper bank:
  - Stimulus: r1 write addr 1030 data 0xC3, then r1 read addr 1030.
  - Response: write cycle has mem_cs=10, mem_addr=6, mem_rw=0; the read returns rdata=0xC3; bank0[6] is unchanged.
- Contention, ARB_ROUND_ROBIN_EN defined:
  - Stimulus: r0 and r1 both requesting, held continuously.
  - Response: grant order r0, r1, r0, r1.
  - Undefined build: r0 on every grant while r0_req stays high.
- Bank boundary:
  - Stimulus: reads at 1023 then 1024.
  - Response: mem_cs=01/mem_addr=1023, then mem_cs=10/mem_addr=0.
  - Checker: mem_cs is never 11 and gnt is never both high.
- Latency, ACC_CYCLES=3:
  - Stimulus: one read request.
  - Response: cs held for exactly 3 cycles; done in cycle 5.
- Reset and request drop:
  - Stimulus: assert rst during ACCESS.
  - Response: next cycle mem_cs=0, mem_rw=1, gnt=0, no done.
  - Follow-on: a request that drops req during SETUP still gets done.
